// File: rtl/oled_spi_pkg.sv
// Shared constants and FSM encoding for the SSD1306 SPI byte transmitter.
package oled_spi_pkg;

  localparam logic DC_CMD  = 1'b0;
  localparam logic DC_DATA = 1'b1;

  // SETUP + 8 x (LOW, HIGH) + HOLD half-periods while cs_n is low
  localparam int BYTE_PHASES = 18;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    LOW,
    HIGH,
    HOLD,
    GAP
  } state_t;

endpackage

// File: rtl/oled_spi_tick_gen.sv
// SCLK half-period timer: one-cycle tick every CLK_DIV cycles while run is high.
// Latency: first tick CLK_DIV cycles after clear; no backpressure.
module oled_spi_tick_gen #(
  parameter int CLK_DIV = 50
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic clear,
  output logic tick
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt;

  assign tick = run && (cnt == LAST);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt <= '0;
    end else if (run) begin
      cnt <= tick ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/oled_spi_byte_tx.sv
// Serialises one byte MSB-first onto 4-wire SPI (mode 3) for an SSD1306-class panel.
// Latency: tx_done 18*CLK_DIV+1 cycles after accept; tx_ready low from accept to end of cs_n gap.
module oled_spi_byte_tx
  import oled_spi_pkg::*;
#(
  parameter int CLK_DIV = 50,
  parameter int CS_GAP  = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  input  logic       tx_dc,
  output logic       tx_ready,
  output logic       tx_done,
  output logic       busy,
  output logic       cs_n,
  output logic       sclk,
  output logic       dc,
  output logic       sdin
);

  localparam int GW = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;
  localparam logic [GW-1:0] GAP_LAST = GW'(CS_GAP - 1);

  state_t          state;
  logic [7:0]      shreg;
  logic [2:0]      bit_idx;
  logic [GW-1:0]   gap_cnt;
  logic            tick;
  logic            accept;

  assign accept = tx_valid && tx_ready;

  oled_spi_tick_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_tick (
    .clk   (clk),
    .rst   (rst),
    .run   (busy),
    .clear (accept),
    .tick  (tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cs_n     <= 1'b1;
      sclk     <= 1'b1;
      sdin     <= 1'b0;
      dc       <= 1'b0;
      tx_ready <= 1'b0;
      tx_done  <= 1'b0;
      busy     <= 1'b0;
      shreg    <= '0;
      bit_idx  <= '0;
      gap_cnt  <= '0;
    end else begin
      tx_done <= 1'b0;
      case (state)
        IDLE: begin
          tx_ready <= !accept;
          if (accept) begin
            state   <= SETUP;
            busy    <= 1'b1;
            cs_n    <= 1'b0;
            sclk    <= 1'b1;
            dc      <= tx_dc;
            shreg   <= tx_data;
            sdin    <= tx_data[7];
            bit_idx <= 3'd7;
          end
        end
        SETUP: begin
          if (tick) begin
            state <= LOW;
            sclk  <= 1'b0;
          end
        end
        LOW: begin
          if (tick) begin
            state <= HIGH;
            sclk  <= 1'b1;
          end
        end
        HIGH: begin
          if (tick) begin
            if (bit_idx == 3'd0) begin
              state <= HOLD;
            end else begin
              // next bit goes out on the falling edge, a full phase before it is sampled
              state   <= LOW;
              sclk    <= 1'b0;
              bit_idx <= bit_idx - 1'b1;
              shreg   <= {shreg[6:0], 1'b0};
              sdin    <= shreg[6];
            end
          end
        end
        HOLD: begin
          if (tick) begin
            state   <= GAP;
            cs_n    <= 1'b1;
            tx_done <= 1'b1;
            gap_cnt <= '0;
          end
        end
        GAP: begin
          if (tick) begin
            if (gap_cnt == GAP_LAST) begin
              state    <= IDLE;
              busy     <= 1'b0;
              tx_ready <= 1'b1;
            end else begin
              gap_cnt <= gap_cnt + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_oled_spi_byte_tx.sv
// Directed bench with a byte/dc scoreboard for oled_spi_byte_tx (CLK_DIV=2 and CLK_DIV=1 instances).
module tb_oled_spi_byte_tx;
  import oled_spi_pkg::*;

  localparam int DIV = 2;
  localparam int GAPP = 1;

  logic       clk = 1'b0;
  logic       rst;
  logic       tx_valid, tx_dc;
  logic [7:0] tx_data;
  logic       tx_ready, tx_done, busy, cs_n, sclk, dc, sdin;

  logic       v1, c1;
  logic [7:0] d1;
  logic       rdy1, done1, busy1, cs1, sclk1, dc1, sdin1;

  always #5 clk = ~clk;

  oled_spi_byte_tx #(.CLK_DIV(DIV), .CS_GAP(GAPP)) u_dut (
    .clk(clk), .rst(rst), .tx_valid(tx_valid), .tx_data(tx_data), .tx_dc(tx_dc),
    .tx_ready(tx_ready), .tx_done(tx_done), .busy(busy), .cs_n(cs_n), .sclk(sclk),
    .dc(dc), .sdin(sdin)
  );

  oled_spi_byte_tx #(.CLK_DIV(1), .CS_GAP(1)) u_dut1 (
    .clk(clk), .rst(rst), .tx_valid(v1), .tx_data(d1), .tx_dc(c1),
    .tx_ready(rdy1), .tx_done(done1), .busy(busy1), .cs_n(cs1), .sclk(sclk1),
    .dc(dc1), .sdin(sdin1)
  );

  int total = 0;
  int bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    total++;
    assert (obs === want) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
    end
  endtask

  // scoreboard entries are {dc, data}
  logic [8:0] sb[$];
  logic [8:0] head;
  int   cyc = 0, acc_cyc = 0, acc_gap = 0, acc_cnt = 0, done_cnt = 0;
  int   nrise = 0, gap_hi = 0, last_gap_hi = 0;
  logic [7:0] rx = '0;
  logic prev_sclk = 1'b1, prev_cs = 1'b1, prev_rst = 1'b1, prev_rdy = 1'b0, prev_sdin = 1'b0;
  logic in_xfer = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      sb.delete();
      in_xfer = 1'b0;
      nrise = 0;
      gap_hi = 0;
    end else begin
      if (!prev_rst) begin
        if (sclk !== prev_sclk) chk("sclk_edge_cs_low", cs_n, 1'b0);
        if (sclk && !prev_sclk) begin
          chk("sdin_stable_at_rise", sdin, prev_sdin);
          rx = {rx[6:0], sdin};
          nrise++;
        end
        if (!cs_n && prev_cs) chk("cs_fall_cycle", cyc - acc_cyc, 1);
      end
      if (!cs_n && sb.size() > 0) chk("dc_in_window", dc, sb[0][8]);
      if (tx_done) begin
        done_cnt++;
        chk("done_cycle", cyc - acc_cyc, 18 * DIV + 1);
        chk("cs_high_at_done", cs_n, 1'b1);
        chk("rise_count", nrise, 8);
        if (sb.size() == 0) chk("done_without_byte", 0, 1);
        else begin
          head = sb.pop_front();
          chk("byte", rx, head[7:0]);
        end
        nrise = 0;
      end
      if (busy && cs_n) gap_hi++;
      if (tx_ready && !prev_rdy && in_xfer) begin
        chk("ready_cycle", cyc - acc_cyc, (18 + GAPP) * DIV + 1);
        in_xfer = 1'b0;
      end
      if (tx_valid && tx_ready) begin
        acc_gap = cyc - acc_cyc;
        last_gap_hi = gap_hi;
        gap_hi = 0;
        acc_cyc = cyc;
        in_xfer = 1'b1;
        acc_cnt++;
        nrise = 0;
        sb.push_back({tx_dc, tx_data});
      end
    end
    prev_sclk = sclk;
    prev_cs   = cs_n;
    prev_rst  = rst;
    prev_rdy  = tx_ready;
    prev_sdin = sdin;
  end

  task automatic send(input logic [7:0] d, input logic c);
    tx_data  = d;
    tx_dc    = c;
    tx_valid = 1'b1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (tx_ready) begin
        @(posedge clk); #1;
        tx_valid = 1'b0;
        return;
      end
    end
    chk("accept_timeout", 0, 1);
    tx_valid = 1'b0;
  endtask

  task automatic wait_idle;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (tx_ready) begin
        @(posedge clk); #1;
        return;
      end
    end
    chk("idle_timeout", 0, 1);
  endtask

  logic [7:0] init_seq [0:28] = '{
    8'hAE, 8'hD5, 8'h80, 8'hA8, 8'h3F, 8'hD3, 8'h00, 8'h40, 8'h8D, 8'h14,
    8'h20, 8'h00, 8'hA1, 8'hC8, 8'hDA, 8'h12, 8'h81, 8'hCF, 8'hD9, 8'hF1,
    8'hDB, 8'h40, 8'hA4, 8'hA6, 8'hAF, 8'h21, 8'h00, 8'h7F, 8'h22
  };

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, a0, rises, first_rise, done_rel;
    logic [7:0] rx1;
    logic prev1;
    bit got;

    rst = 1'b1; tx_valid = 1'b0; tx_data = '0; tx_dc = 1'b0;
    v1 = 1'b0; d1 = '0; c1 = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_cs_n", cs_n, 1'b1);
    chk("rst_sclk", sclk, 1'b1);
    chk("rst_sdin", sdin, 1'b0);
    chk("rst_dc", dc, 1'b0);
    chk("rst_ready", tx_ready, 1'b0);
    chk("rst_done", tx_done, 1'b0);
    chk("rst_busy", busy, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("ready_before_release_edge", tx_ready, 1'b0);
    @(negedge clk);
    chk("ready_after_release", tx_ready, 1'b1);
    @(posedge clk); #1;

    // T1: single command byte
    send(8'hA5, DC_CMD);
    wait_idle();
    chk("t1_sb_empty", sb.size(), 0);

    // T2: back-to-back data bytes with tx_valid held through the gap
    send(8'hFF, DC_DATA);
    send(8'h00, DC_DATA);
    chk("t2_second_accept_cycle", acc_gap, 39);
    chk("t2_cs_high_gap_cycles", last_gap_hi, 2);
    wait_idle();

    // T3: input changes and stray valid pulses during a transfer
    a0 = acc_cnt;
    send(8'hC3, DC_DATA);
    repeat (4) @(posedge clk); #1;
    tx_data = 8'h3C;
    tx_dc   = DC_CMD;
    for (int k = 0; k < 3; k++) begin
      tx_valid = 1'b1;
      @(posedge clk); #1;
      tx_valid = 1'b0;
      repeat (3) @(posedge clk); #1;
    end
    wait_idle();
    chk("t3_single_accept", acc_cnt - a0, 1);
    chk("t3_sb_empty", sb.size(), 0);

    // T4: reset in cycle 15 of a transfer
    d0 = done_cnt;
    send(8'h5A, DC_DATA);
    repeat (14) @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("t4_cs_n", cs_n, 1'b1);
    chk("t4_sclk", sclk, 1'b1);
    chk("t4_busy", busy, 1'b0);
    chk("t4_done", tx_done, 1'b0);
    repeat (60) @(negedge clk);
    chk("t4_no_done", done_cnt - d0, 0);
    @(posedge clk); #1;
    send(8'h81, DC_CMD);
    wait_idle();
    chk("t4_fresh_done", done_cnt - d0, 1);

    // T5: CLK_DIV=1 instance
    d1 = 8'h01; c1 = DC_CMD; v1 = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      if (rdy1) got = 1'b1;
    end
    chk("t5_accept", got, 1'b1);
    @(posedge clk); #1;
    v1 = 1'b0;
    rises = 0; first_rise = 0; done_rel = 0; rx1 = '0; prev1 = 1'b1;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (sclk1 && !prev1) begin
        rises++;
        rx1 = {rx1[6:0], sdin1};
        if (first_rise == 0) first_rise = i;
      end
      prev1 = sclk1;
      if (done1) done_rel = i;
    end
    chk("t5_done_cycle", done_rel, 19);
    chk("t5_rises", rises, 8);
    chk("t5_first_rise", first_rise, 3);
    chk("t5_byte", rx1, 8'h01);
    @(posedge clk); #1;

    // T6: init sequence followed by a full zero frame
    d0 = done_cnt;
    for (int i = 0; i < 29; i++) send(init_seq[i], DC_CMD);
    for (int i = 0; i < 1024; i++) send(8'h00, DC_DATA);
    wait_idle();
    chk("t6_byte_count", done_cnt - d0, 1053);
    chk("t6_sb_empty", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
